// File: rtl/div_pkg.sv
// div_pkg: shared state type and constants for the sequential divider
package div_pkg;
  localparam int DW_DEFAULT = 8;
  localparam int NW_DEFAULT = 16;
  localparam logic [NW_DEFAULT-1:0] DIV0_QUOTIENT = '1;
  localparam logic [DW_DEFAULT-1:0] DIV0_REMAINDER = '0;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_16by8_seq_if.sv
// div_16by8_seq_if: request/result handshake bundle between requester (master) and divider (slave)
interface div_16by8_seq_if import div_pkg::*; #(
  parameter int DW = DW_DEFAULT,
  parameter int NW = NW_DEFAULT
);
  logic in_valid;
  logic in_ready;
  logic [NW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic out_valid;
  logic out_ready;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic div_zero;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input in_ready, out_valid, quotient, remainder, div_zero
  );
  modport slave (
    input in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division step (shift in a dividend bit, conditionally subtract)
module div_restore_step import div_pkg::*; #(
  parameter int DW = DW_DEFAULT
) (
  input logic [DW:0] pr_in,
  input logic bit_in,
  input logic [DW-1:0] divisor,
  output logic [DW:0] pr_out,
  output logic q_bit
);
  logic [DW:0] sh;
  logic unused_pr_top;
  assign unused_pr_top = pr_in[DW];
  always_comb begin
    sh = {pr_in[DW-1:0], bit_in};
    q_bit = sh >= {1'b0, divisor};
    pr_out = q_bit ? sh - {1'b0, divisor} : sh;
  end
endmodule

// File: rtl/div_16by8_seq.sv
// div_16by8_seq: sequential restoring 16/8 unsigned divider, one quotient bit per clock
module div_16by8_seq import div_pkg::*; #(
  parameter int DW = DW_DEFAULT,
  parameter int NW = NW_DEFAULT
) (
  input logic clk,
  input logic rst,
  div_16by8_seq_if.slave bus
);
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] Q_DIV0 = NW'(DIV0_QUOTIENT);
  localparam logic [DW:0] R_DIV0 = (DW+1)'(DIV0_REMAINDER);
  state_t state, state_nx;
  logic [NW-1:0] q_sh;
  logic [DW:0] pr, pr_nx;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic q_bit, dz, ov, accept, zero_in;
  assign accept = state == IDLE && bus.in_valid;
  assign zero_in = bus.divisor == '0;
  div_restore_step #(.DW(DW)) u_step (
    .pr_in(pr),
    .bit_in(q_sh[NW-1]),
    .divisor(dvs),
    .pr_out(pr_nx),
    .q_bit(q_bit)
  );
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = bus.in_valid ? (zero_in ? DONE : CALC) : IDLE;
      CALC: state_nx = cnt == '0 ? DONE : CALC;
      DONE: state_nx = ov && bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q_sh <= '0;
      pr <= '0;
      dvs <= '0;
      cnt <= '0;
      dz <= 1'b0;
      ov <= 1'b0;
    end else begin
      state <= state_nx;
      ov <= state == DONE && !(ov && bus.out_ready);
      if (accept) begin
        dvs <= bus.divisor;
        cnt <= CW'(NW-1);
        dz <= zero_in;
        q_sh <= zero_in ? Q_DIV0 : bus.dividend;
        pr <= zero_in ? R_DIV0 : '0;
      end else if (state == CALC) begin
        q_sh <= {q_sh[NW-2:0], q_bit};
        pr <= pr_nx;
        cnt <= cnt - CW'(1);
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = ov;
  assign bus.quotient = q_sh;
  assign bus.remainder = pr[DW-1:0];
  assign bus.div_zero = dz;
endmodule
